// File: rtl/axpy_pkg.sv
// axpy_pkg: shared definitions for the AXPY write-back unit.
//   - default parameter values for the top and lane modules
//   - FSM state enumeration
//   - fx_mul: signed fixed-point multiply with an arithmetic right shift
package axpy_pkg;

    localparam int unsigned DEF_NO_OF_UNITS   = 8;
    localparam int unsigned DEF_ELEMENT_WIDTH = 64;
    localparam int unsigned DEF_FRAC_BITS     = 32;
    localparam int unsigned DEF_MUL_LATENCY   = 3;

    // Widest element fx_mul can handle; narrower elements are sign-extended.
    localparam int unsigned MAX_EW = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    // Full-precision signed product, arithmetic-shifted right by frac.
    // The caller truncates the result to its element width.
    function automatic logic signed [2*MAX_EW-1:0] fx_mul(
        input logic signed [MAX_EW-1:0] x,
        input logic signed [MAX_EW-1:0] y,
        input int unsigned              frac
    );
        logic signed [2*MAX_EW-1:0] xe;
        logic signed [2*MAX_EW-1:0] ye;
        xe = (2*MAX_EW)'(x);
        ye = (2*MAX_EW)'(y);
        return (xe * ye) >>> frac;
    endfunction

endpackage

// File: rtl/axpy_lane.sv
// axpy_lane: one lane of the AXPY write-back datapath.
//   clk      rising-edge clock
//   clear    synchronous clear (reset or abort)
//   scalar   latched signed multiplier s
//   subtract 1: a - s*b, 0: a + s*b
//   load     result register update strobe (row leaving the pipeline)
//   a, b     lane operands from the source row
//   result   registered lane result
module axpy_lane
    import axpy_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int unsigned FRAC_BITS     = DEF_FRAC_BITS,
    parameter int unsigned MUL_LATENCY   = DEF_MUL_LATENCY
) (
    input  logic                            clk,
    input  logic                            clear,
    input  logic signed [ELEMENT_WIDTH-1:0] scalar,
    input  logic                            subtract,
    input  logic                            load,
    input  logic        [ELEMENT_WIDTH-1:0] a,
    input  logic signed [ELEMENT_WIDTH-1:0] b,
    output logic        [ELEMENT_WIDTH-1:0] result
);

    logic [ELEMENT_WIDTH-1:0] product;
    logic [ELEMENT_WIDTH-1:0] p_pipe [MUL_LATENCY];
    logic [ELEMENT_WIDTH-1:0] a_pipe [MUL_LATENCY];

    // Product is formed at the input and carried through MUL_LATENCY
    // registers so synthesis can retime the multiplier across them.
    assign product = ELEMENT_WIDTH'(fx_mul(MAX_EW'(scalar), MAX_EW'(b), FRAC_BITS));

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
                p_pipe[i] <= '0;
                a_pipe[i] <= '0;
            end
            result <= '0;
        end else begin
            p_pipe[0] <= product;
            a_pipe[0] <= a;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                p_pipe[i] <= p_pipe[i-1];
                a_pipe[i] <= a_pipe[i-1];
            end
            if (load) begin
                result <= subtract ? a_pipe[MUL_LATENCY-1] - p_pipe[MUL_LATENCY-1]
                                   : a_pipe[MUL_LATENCY-1] + p_pipe[MUL_LATENCY-1];
            end
        end
    end

endmodule

// File: rtl/axpy_writeback_unit.sv
// axpy_writeback_unit: row-streaming r = a +/- s*b over NO_OF_UNITS lanes.
//   clk, reset          clock, synchronous active-high reset
//   abort               synchronous clear, same effect as reset
//   start               one-cycle pass start (IDLE only)
//   total               element count; rows = total / NO_OF_UNITS
//   scalar, subtract    operands latched at start
//   read_again          one-cycle request for the next source row
//   in_valid,in_a,in_b  returned source row
//   result_mem_we       result write strobe
//   result_mem_counter  result row address
//   result_data         result row
//   busy, done          pass status
module axpy_writeback_unit
    import axpy_pkg::*;
#(
    parameter int unsigned NO_OF_UNITS   = DEF_NO_OF_UNITS,
    parameter int unsigned ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int unsigned FRAC_BITS     = DEF_FRAC_BITS,
    parameter int unsigned MUL_LATENCY   = DEF_MUL_LATENCY
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   abort,
    input  logic                                   start,
    input  logic [31:0]                            total,
    input  logic [ELEMENT_WIDTH-1:0]               scalar,
    input  logic                                   subtract,
    output logic                                   read_again,
    input  logic                                   in_valid,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   in_a,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   in_b,
    output logic                                   result_mem_we,
    output logic [31:0]                            result_mem_counter,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0]   result_data,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned EW = ELEMENT_WIDTH;

    state_t                 state;
    logic [31:0]            rows_q;
    logic [31:0]            issued;
    logic [31:0]            received;
    logic [31:0]            written;
    logic [EW-1:0]          scalar_q;
    logic                   sub_q;
    logic [MUL_LATENCY-1:0] vld;
    logic                   vld_last;
    logic                   accept;
    logic                   clear;

    assign clear    = reset | abort;
    assign accept   = in_valid && (state != IDLE) && (received != rows_q);
    assign vld_last = vld[MUL_LATENCY-1];

    always_ff @(posedge clk) begin
        if (clear) begin
            state              <= IDLE;
            rows_q             <= '0;
            issued             <= '0;
            received           <= '0;
            written            <= '0;
            scalar_q           <= '0;
            sub_q              <= 1'b0;
            vld                <= '0;
            read_again         <= 1'b0;
            result_mem_we      <= 1'b0;
            result_mem_counter <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            vld[0] <= accept;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
            result_mem_we <= vld_last;

            if (accept) begin
                received <= received + 32'd1;
            end
            // Counts rows as they enter the result register, one cycle
            // ahead of the matching result_mem_we.
            if (vld_last) begin
                written <= written + 32'd1;
            end
            if (result_mem_we) begin
                result_mem_counter <= (result_mem_counter == rows_q - 32'd1)
                                      ? '0 : result_mem_counter + 32'd1;
            end

            read_again <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q             <= total / NO_OF_UNITS;
                        scalar_q           <= scalar;
                        sub_q              <= subtract;
                        issued             <= '0;
                        received           <= '0;
                        written            <= '0;
                        result_mem_counter <= '0;
                        busy               <= 1'b1;
                        state              <= (total / NO_OF_UNITS == 32'd0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (issued < rows_q) begin
                        read_again <= 1'b1;
                        issued     <= issued + 32'd1;
                    end
                    if (issued + 32'd1 >= rows_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // FINISH is entered alongside the final write so the
                    // registered done lands on the following cycle.
                    if ((written == rows_q) || (vld_last && (written + 32'd1 == rows_q))) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NO_OF_UNITS; i++) begin : g_lane
        axpy_lane #(
            .ELEMENT_WIDTH (EW),
            .FRAC_BITS     (FRAC_BITS),
            .MUL_LATENCY   (MUL_LATENCY)
        ) u_lane (
            .clk      (clk),
            .clear    (clear),
            .scalar   (scalar_q),
            .subtract (sub_q),
            .load     (vld_last),
            .a        (in_a[i*EW +: EW]),
            .b        (in_b[i*EW +: EW]),
            .result   (result_data[i*EW +: EW])
        );
    end

endmodule

// File: tb/tb_axpy_writeback_unit.sv
// Testbench for axpy_writeback_unit: table-driven single/dual-row passes
// with hand-computed lane results, plus reset/abort and gapped sequences.
module tb_axpy_writeback_unit;

    localparam int N  = 8;
    localparam int EW = 64;
    localparam int FB = 32;
    localparam int L  = 3;

    logic              clk = 1'b0;
    logic              reset, abort, start, subtract, in_valid;
    logic [31:0]       total;
    logic [EW-1:0]     scalar;
    logic [N*EW-1:0]   in_a, in_b;
    logic              read_again, result_mem_we, busy, done;
    logic [31:0]       result_mem_counter;
    logic [N*EW-1:0]   result_data;

    int cyc = 0;
    int total_n = 0;
    int bad_n = 0;

    axpy_writeback_unit #(
        .NO_OF_UNITS   (N),
        .ELEMENT_WIDTH (EW),
        .FRAC_BITS     (FB),
        .MUL_LATENCY   (L)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .abort              (abort),
        .start              (start),
        .total              (total),
        .scalar             (scalar),
        .subtract           (subtract),
        .read_again         (read_again),
        .in_valid           (in_valid),
        .in_a               (in_a),
        .in_b               (in_b),
        .result_mem_we      (result_mem_we),
        .result_mem_counter (result_mem_counter),
        .result_data        (result_data),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [N*EW-1:0] act, input logic [N*EW-1:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] s, input logic sub);
        logic signed [127:0] sx, bx, pr;
        sx = {{64{s[63]}}, s};
        bx = {{64{b[63]}}, b};
        pr = (sx * bx) >>> FB;
        return sub ? a - pr[63:0] : a + pr[63:0];
    endfunction

    // One pass. vary=0: every lane/row gets a,b and must produce exp_lane.
    // vary=1: row r adds r to a's integer part, lane i adds i LSBs to b.
    // stop_at>0: reset (or abort) is asserted during that write.
    task automatic run_pass(input int tot, input logic [63:0] s, input logic [63:0] a,
                            input logic [63:0] b, input logic sub, input bit vary,
                            input logic [63:0] exp_lane, input int gap_max,
                            input int stop_at, input bit use_abort);
        int rows, wr, rcv, nreq, ndone, gap, tail, start_cyc, last_we, done_cyc, stray;
        int req_q[$];
        int iv_q[$];
        bit stopped, rst_chk;
        logic [N*EW-1:0] exp_row;
        logic [63:0] al, bl;
        rows = tot / N;
        wr = 0; rcv = 0; nreq = 0; ndone = 0; gap = 0; tail = -1;
        last_we = -1; done_cyc = -1; stray = 0; stopped = 0; rst_chk = 0;
        @(negedge clk);
        total = tot; scalar = s; subtract = sub; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; scalar = ~s; subtract = ~sub; total = 32'hFFFF_FFFF;
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < 600; k++) begin
            if (rst_chk) begin
                chk("stop_clears_we",   result_mem_we, 0);
                chk("stop_clears_ra",   read_again, 0);
                chk("stop_clears_busy", busy, 0);
                chk("stop_clears_done", done, 0);
                chk("stop_clears_cnt",  result_mem_counter, 0);
                chk_row("stop_clears_data", result_data, '0);
                reset = 1'b0; abort = 1'b0; rst_chk = 0;
            end
            if (read_again) begin
                nreq++;
                req_q.push_back(cyc);
            end
            if (result_mem_we) begin
                if (stopped) begin
                    stray++;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        al = vary ? a + (64'(wr) << 32) : a;
                        bl = vary ? b + 64'(i) : b;
                        exp_row[i*EW +: EW] = vary ? model(al, bl, s, sub) : exp_lane;
                    end
                    chk_row("row_data", result_data, exp_row);
                    chk("row_addr", result_mem_counter, 64'(wr));
                    chk("row_latency", (wr < iv_q.size()) ? 64'(cyc - iv_q[wr]) : '1, 64'(L + 1));
                    last_we = cyc;
                    wr++;
                    if (stop_at == wr) begin
                        if (use_abort) abort = 1'b1;
                        else reset = 1'b1;
                        stopped = 1; rst_chk = 1; tail = 12;
                    end
                end
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
                if (tail < 0) tail = 4;
            end
            in_valid = 1'b0;
            if (!stopped) begin
                if (gap > 0) begin
                    gap--;
                end else if (req_q.size() > 0 && req_q[0] < cyc) begin
                    void'(req_q.pop_front());
                    for (int i = 0; i < N; i++) begin
                        in_a[i*EW +: EW] = vary ? a + (64'(rcv) << 32) : a;
                        in_b[i*EW +: EW] = vary ? b + 64'(i) : b;
                    end
                    in_valid = 1'b1;
                    iv_q.push_back(cyc);
                    rcv++;
                    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                end
            end
            if (tail == 0) break;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (stop_at == 0) begin
            chk("write_count", 64'(wr), 64'(rows));
            chk("request_count", 64'(nreq), 64'(rows));
            chk("done_count", 64'(ndone), 1);
            chk("done_cycle", 64'(done_cyc), (rows == 0) ? 64'(start_cyc + 2) : 64'(last_we + 1));
            chk("counter_back_to_0", result_mem_counter, 0);
        end else begin
            chk("no_we_after_stop", 64'(stray), 0);
            chk("no_done_after_stop", 64'(ndone), 0);
        end
    endtask

    typedef struct {
        int          tot;
        logic [63:0] s;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];
    int   ra_cnt;

    initial begin
        // total, s, a, b, subtract, expected lane value (Q32.32)
        vecs[0] = '{16, 64'h00000001_00000000, 64'h00000003_00000000, 64'h00000002_00000000, 1'b1, 64'h00000001_00000000};
        vecs[1] = '{0,  64'h00000001_00000000, 64'h00000003_00000000, 64'h00000002_00000000, 1'b0, 64'h0};
        vecs[2] = '{20, 64'hFFFFFFFF_80000000, 64'h0,                 64'h00000004_00000000, 1'b0, 64'hFFFFFFFE_00000000};
        vecs[3] = '{8,  64'h00000001_00000000, 64'h7FFFFFFF_FFFFFFFF, 64'h1,                 1'b0, 64'h80000000_00000000};
        vecs[4] = '{8,  64'h00000003_00000000, 64'h00000001_80000000, 64'h00000000_80000000, 1'b0, 64'h00000003_00000000};
        vecs[5] = '{15, 64'hFFFFFFFF_00000000, 64'h0,                 64'hFFFFFFFF_00000000, 1'b1, 64'hFFFFFFFF_00000000};
        vecs[6] = '{8,  64'h00000000_80000000, 64'h0,                 64'h1,                 1'b0, 64'h0};
        vecs[7] = '{8,  64'h00000000_80000000, 64'h0,                 64'hFFFFFFFF_FFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
        vecs[8] = '{8,  64'h00000001_00000000, 64'h80000000_00000000, 64'h1,                 1'b1, 64'h7FFFFFFF_FFFFFFFF};

        reset = 1'b1; abort = 1'b0; start = 1'b0; subtract = 1'b0; in_valid = 1'b0;
        total = '0; scalar = '0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_we",   result_mem_we, 0);
        chk("reset_ra",   read_again, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cnt",  result_mem_counter, 0);
        chk_row("reset_data", result_data, '0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_pass(vecs[v].tot, vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].sub, 1'b0,
                     vecs[v].exp, 0, 0, 1'b0);
        end

        // abort wins over a simultaneous start
        @(negedge clk);
        total = 32'd16; scalar = 64'h00000001_00000000; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", busy, 0);
        ra_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (read_again) ra_cnt++;
        end
        chk("no_request_after_abort", 64'(ra_cnt), 0);

        // reset on the 3rd write, then a clean 8-row pass
        run_pass(64, 64'h00000001_00000000, 64'h00000010_00000000, 64'h00000002_00000000,
                 1'b1, 1'b1, '0, 0, 3, 1'b0);
        run_pass(64, 64'hFFFFFFFE_80000000, 64'h00000010_00000000, 64'h00000002_40000000,
                 1'b0, 1'b1, '0, 0, 0, 1'b0);
        // random gaps between returned rows
        run_pass(64, 64'h00000002_00000000, 64'hFFFFFFF0_00000000, 64'h00000001_00000000,
                 1'b1, 1'b1, '0, 3, 0, 1'b0);
        // abort mid-pass, then recovery
        run_pass(64, 64'h00000001_00000000, 64'h0, 64'h00000005_00000000,
                 1'b0, 1'b1, '0, 1, 2, 1'b1);
        run_pass(24, 64'h00000000_40000000, 64'h00000001_00000000, 64'h00000008_00000000,
                 1'b0, 1'b1, '0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
